instruction_fetch_unit: RTL and testbench

//  Fetch stage between the instruction memory read port and the decoder. On start, streams
//  num_instr words from base_addr out of imem (1-cycle registered read latency) into a small

---
 rtl/inst_fetch_pkg.sv | 15 +
 rtl/inst_fetch_fifo.sv | 52 +++++
 rtl/instruction_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// the default word/address widths of the instruction memory it reads from.
package inst_fetch_pkg;

  localparam int IMEM_DATA_WIDTH = 32;
  localparam int IMEM_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO buffering fetched words for the decoder. Head data reads
// as zero while empty so the output is defined straight out of reset.
module inst_fetch_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: streams num_instr words from imem into a credit-protected FIFO
// feeding the decoder. Optional stall counter under INST_FETCH_STALL_CNT_EN.
module instruction_fetch_unit
  import inst_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int COUNT_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_W-1:0]    num_instr,
  output logic                  busy,
  output logic                  done,
  output logic                  imem_read_req,
  output logic [ADDR_WIDTH-1:0] imem_read_addr,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  inst_ready,
  output logic [31:0]           stall_cycles
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state_q;
  fetch_state_t          state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [COUNT_W-1:0]    num_q;
  logic [COUNT_W-1:0]    issued_q;
  logic [COUNT_W-1:0]    accepted_q;
  logic                  pend_q;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  start_accept;
  logic                  handshake;
  logic                  credit_ok;

  // Decoder handshake: a word transfers on any cycle with inst_valid & inst_ready;
  // inst_data is stable while inst_valid is high and inst_ready is low.
  assign start_accept = (state_q == ST_IDLE) & start;
  assign handshake    = inst_valid & inst_ready;
  // A pop in the same cycle frees no credit, so the FIFO can never overflow.
  assign credit_ok    = (int'(fifo_count) + int'(pend_q)) < FIFO_DEPTH;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_instr != '0) ? ST_FETCH : ST_DONE;
      end
      ST_FETCH: begin
        if (issued_q == num_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accepted_q == num_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != ST_IDLE);
    done           = (state_q == ST_DONE);
    imem_read_req  = (state_q == ST_FETCH) & (issued_q < num_q) & credit_ok;
    imem_read_addr = addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      pend_q <= imem_read_req;
      if (start_accept) begin
        addr_q     <= base_addr;
        num_q      <= num_instr;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (imem_read_req) begin
          addr_q   <= addr_q + 1'b1;
          issued_q <= issued_q + 1'b1;
        end
        if (handshake) accepted_q <= accepted_q + 1'b1;
      end
    end
  end

  inst_fetch_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pend_q),
    .push_data(imem_read_data),
    .pop      (handshake),
    .head_data(inst_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign inst_valid = ~fifo_empty;

`ifdef INST_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset)                                          stall_q <= '0;
    else if (start_accept)                              stall_q <= '0;
    else if (inst_valid & ~inst_ready & (stall_q != '1)) stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  // Full is implied by the credit rule; kept on the FIFO interface for checkers.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven fetch runs, reset/restart
// sequences and randomized backpressure against a queue-based reference.
module tb_instruction_fetch_unit;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int CW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_instr;
  logic          busy;
  logic          done;
  logic          imem_read_req;
  logic [AW-1:0] imem_read_addr;
  logic [DW-1:0] imem_read_data;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic          inst_ready;
  logic [31:0]   stall_cycles;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_instr     (num_instr),
    .busy          (busy),
    .done          (done),
    .imem_read_req (imem_read_req),
    .imem_read_addr(imem_read_addr),
    .imem_read_data(imem_read_data),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_ready    (inst_ready),
    .stall_cycles  (stall_cycles)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- imem model: registered read, garbage when idle ----------------
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a, 10'h2B5};
  endfunction

  always @(posedge clk) begin
    if (imem_read_req) imem_read_data <= mem_word(imem_read_addr);
    else               imem_read_data <= $urandom();
  end

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            acc_cyc[$];
  int            done_cyc[$];
  int            busy_cnt, reads_seen, reads_low, model_stall, max_out, stable_err;
  int            run_s, run_low;
  bit            mon_en = 1'b0;
  bit            held_valid;
  logic [DW-1:0] held_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_true(input string name, input bit cond, input logic [63:0] act);
    total_cnt++;
    if (cond) pass_cnt++;
    else $display("FAIL %s: actual=%0h violates required condition (cycle %0d)", name, act, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy) busy_cnt++;
      if (done) done_cyc.push_back(cyc);
      if (imem_read_req) begin
        check_true("read_expected", exp_addr_q.size() != 0, imem_read_addr);
        if (exp_addr_q.size() != 0) check("read_addr", imem_read_addr, exp_addr_q.pop_front());
        reads_seen++;
        if (cyc - run_s < run_low) reads_low++;
      end
      if (reads_seen - acc_cyc.size() > max_out) max_out = reads_seen - acc_cyc.size();
      if (held_valid && (!inst_valid || inst_data !== held_data)) stable_err++;
      if (inst_valid && inst_ready) begin
        check_true("accept_expected", exp_q.size() != 0, inst_data);
        if (exp_q.size() != 0) check("inst_data", inst_data, exp_q.pop_front());
        acc_cyc.push_back(cyc);
      end
      if (inst_valid && !inst_ready) model_stall++;
      held_valid = inst_valid && !inst_ready;
      held_data  = inst_data;
    end
  end

  // ---------------- driver ----------------
  task automatic setup_model(input logic [AW-1:0] base, input logic [CW-1:0] num, input int low);
    logic [AW-1:0] a;
    exp_q.delete();
    exp_addr_q.delete();
    acc_cyc.delete();
    done_cyc.delete();
    for (int i = 0; i < int'(num); i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_word(a));
    end
    busy_cnt = 0; reads_seen = 0; reads_low = 0; model_stall = 0;
    max_out = 0; stable_err = 0; held_valid = 1'b0;
    run_low = low;
  endtask

  task automatic run_fetch(input logic [AW-1:0] base, input logic [CW-1:0] num, input int low,
                           input bit rand_ready, input int restart_at);
    setup_model(base, num, low);
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_instr = num;
    inst_ready = (low == 0) && !rand_ready;
    run_s = cyc + 1;
    @(posedge clk); #1;
    base_addr = AW'($urandom()); num_instr = CW'($urandom());
    for (int t = 0; t < 600; t++) begin
      if (done_cyc.size() > 0 && cyc >= done_cyc[0] + 3) break;
      start = (restart_at >= 0) && (cyc - run_s == restart_at);
      if (start) begin base_addr = 11'h300; num_instr = 16'd2; end
      inst_ready = rand_ready ? 1'($urandom_range(0, 1)) : (cyc - run_s >= low);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_pulses", done_cyc.size(), 1);
    check("all_words_delivered", exp_q.size(), 0);
    check("all_reads_issued", exp_addr_q.size(), 0);
    check_true("credit_bound", max_out <= DEPTH, max_out);
    check("hold_stable", stable_err, 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [CW-1:0] num;
    int            low;
    int            restart_at;
    int            exp_first_acc;
    int            exp_done_rel;
    int            exp_reads_low;
    int            exp_stall;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int gaps;
    vecs[0] = '{11'h010, 16'd5, 0,  -1, 2,  8,  -1, 0};
    vecs[1] = '{11'h020, 16'd8, 10, -1, 10, 19, 4,  8};
    vecs[2] = '{11'h7FE, 16'd4, 0,  -1, 2,  7,  -1, 0};
    vecs[3] = '{11'h055, 16'd0, 0,  -1, -1, 0,  -1, 0};
    vecs[4] = '{11'h100, 16'd6, 0,  2,  2,  9,  -1, 0};
    vecs[5] = '{11'h200, 16'd3, 9,  -1, 9,  13, 3,  7};

    reset = 1'b1; start = 1'b0; base_addr = '0; num_instr = '0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_req", imem_read_req, 0);
    check("reset_addr", imem_read_addr, 0);
    check("reset_valid", inst_valid, 0);
    check("reset_data", inst_data, 0);
    check("reset_stall", stall_cycles, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_fetch(vecs[v].base, vecs[v].num, vecs[v].low, 1'b0, vecs[v].restart_at);
      if (vecs[v].exp_first_acc >= 0)
        check($sformatf("v%0d_first_accept", v), acc_cyc.size() ? acc_cyc[0] - run_s : -1,
              vecs[v].exp_first_acc);
      check($sformatf("v%0d_done_latency", v), done_cyc.size() ? done_cyc[0] - run_s : -1,
            vecs[v].exp_done_rel);
      check($sformatf("v%0d_busy_cycles", v), busy_cnt, vecs[v].exp_done_rel + 1);
      if (vecs[v].exp_reads_low >= 0)
        check($sformatf("v%0d_reads_while_stalled", v), reads_low, vecs[v].exp_reads_low);
      gaps = 0;
      for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] != acc_cyc[i-1] + 1) gaps++;
      check($sformatf("v%0d_back_to_back", v), gaps, 0);
`ifdef INST_FETCH_STALL_CNT_EN
      check($sformatf("v%0d_stall_cycles", v), stall_cycles, vecs[v].exp_stall);
`else
      check($sformatf("v%0d_stall_cycles", v), stall_cycles, 0);
`endif
    end

    // Reset while draining: outputs return to reset values, nothing completes.
    setup_model(11'h040, 16'd4, 1000);
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'h040; num_instr = 16'd4; inst_ready = 1'b0;
    run_s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 50 && cyc < run_s + 6; t++) begin @(posedge clk); #1; end
    check("drain_reads_done", exp_addr_q.size(), 0);
    check("drain_busy", busy, 1);
    reset = 1'b1; mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_req", imem_read_req, 0);
    check("midrst_addr", imem_read_addr, 0);
    check("midrst_valid", inst_valid, 0);
    check("midrst_data", inst_data, 0);
    check("midrst_stall", stall_cycles, 0);
    @(posedge clk); #1;
    reset = 1'b0; inst_ready = 1'b1;
    setup_model(11'h040, 16'd0, 0);
    mon_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_done", done_cyc.size(), 0);
    check("midrst_no_words", acc_cyc.size(), 0);

    // Randomized runs with random backpressure.
    for (int r = 0; r < 12; r++) begin
      run_fetch(AW'($urandom_range(0, 2047)), CW'($urandom_range(1, 20)), 0, 1'b1, -1);
`ifdef INST_FETCH_STALL_CNT_EN
      check($sformatf("rand%0d_stall", r), stall_cycles, model_stall);
`else
      check($sformatf("rand%0d_stall", r), stall_cycles, 0);
`endif
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
